// File: rtl/if_prefetch.sv
// if_prefetch -- instruction-fetch stage with a small in-order prefetch queue.
//
// Drives the instruction memory address from fetch_pc, captures the returned
// word together with its PC into a DEPTH-entry FIFO and hands entries to
// decode over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the new (word-aligned) target.
//
// Optional feature macro: IF_PERF_EN (adds perf_fetch_cnt / perf_flush_cnt).
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   im_addr         out  instruction memory byte address (= fetch_pc)
//   im_dout         in   instruction word at im_addr, same cycle
//   redirect_valid  in   taken branch / jump this cycle
//   redirect_pc     in   new fetch target, bits [1:0] ignored
//   id_ready        in   decode accepts head entry
//   id_valid        out  head entry valid
//   id_pc           out  PC of head entry (0 when empty)
//   id_inst         out  instruction of head entry (0 when empty)
//   perf_fetch_cnt  out  pushes counted (IF_PERF_EN only)
//   perf_flush_cnt  out  redirects counted (IF_PERF_EN only)

module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic pop, push;

    assign id_valid = (count_q != '0);
    assign pop      = id_valid && id_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign push     = !redirect_valid && ((count_q < DEPTH_C) || pop);
    assign im_addr  = fetch_pc_q;

    assign id_pc    = id_valid ? pc_mem[rd_ptr_q]   : 32'h0;
    assign id_inst  = id_valid ? inst_mem[rd_ptr_q] : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Flush wins: any pop this cycle is dropped, nothing is pushed.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage carries no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= im_dout;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + (push ? 32'd1 : 32'd0);
        perf_flush_d = perf_flush_q + (redirect_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word derived from the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign im_dout = word_of(im_addr);

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(id_valid), 32'd1);
        chk({tag, "_pc"},    id_pc,         pc);
        chk({tag, "_inst"},  id_inst,       word_of(pc));
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc",    id_pc,         32'h0);
        chk("rst_inst",  id_inst,       32'h0);
        chk("rst_addr",  im_addr,       32'h0);

        // Streaming with id_ready high: one per cycle, no bubble
        id_ready = 1'b1; rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            head($sformatf("stream%0d", k), 32'(4*k));
            chk($sformatf("stream%0d_addr", k), im_addr, 32'(4*k + 4));
        end

        // Fill with id_ready low: saturates at DEPTH, im_addr holds at 0x10
        rst = 1'b1; id_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("fill%0d_addr", k), im_addr, 32'(4*((k < 4) ? k : 4)));
        end
        head("full_head", 32'h0);

        // Full + pop: push still occurs; delivery continues without bubble
        id_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            head($sformatf("drain%0d", k), 32'(4*k));
            chk($sformatf("drain%0d_addr", k), im_addr, 32'(16 + 4*k));
        end
        // Count must still be DEPTH: a stall cycle must not push
        id_ready = 1'b0;
        step();
        chk("stall_addr", im_addr, 32'h24);
        head("stall_head", 32'h14);

        // Redirect with 3 entries queued and id_ready high
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("pre_redir_addr", im_addr, 32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; id_ready = 1'b1;
        step();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        chk("redir_valid", 32'(id_valid), 32'd0);
        chk("redir_addr",  im_addr,       32'h100);
        chk("redir_pc",    id_pc,         32'h0);
        step();
        head("redir_tgt", 32'h100);
        // Queue two entries (half full)
        id_ready = 1'b0;
        step();
        head("half_head", 32'h100);
        chk("half_addr", im_addr, 32'h108);

        // Mid-stream reset wins over redirect and pop
        rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_addr",  im_addr,       32'h0);
        step();
        head("mrst_0", 32'h0);
        step();
        head("mrst_1", 32'h4);

`ifdef IF_PERF_EN
        rst = 1'b1; id_ready = 1'b1;
        step();
        chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_rst_flush", perf_flush_cnt, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); step();
        redirect_valid = 1'b0;
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_flush", perf_flush_cnt, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("perf_clr_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_clr_flush", perf_flush_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
